// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the instruction packer: immediate formats,
// opcodes and the captured input beat layout.
package rv_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // imm_src stays raw so out-of-range format codes survive capture
  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  imm_src;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } beat_t;

endpackage

// File: rtl/imm_packer_if.sv
// Beat input, imem write port and sticky status of the instruction packer.
interface imm_packer_if #(
  parameter int ADDR_W = 8
) ();

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_imm;
  logic [2:0]        in_imm_src;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              done;
  logic              full;
  logic              err_range;
  logic              err_align;
  logic              err_format;

  modport master (
    output start, in_valid, in_imm, in_imm_src, in_opcode, in_rd, in_rs1,
           in_rs2, in_funct3, in_funct7, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, word_count, done, full,
           err_range, err_align, err_format
  );

  modport slave (
    input  start, in_valid, in_imm, in_imm_src, in_opcode, in_rd, in_rs1,
           in_rs2, in_funct3, in_funct7, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, word_count, done, full,
           err_range, err_align, err_format
  );

endinterface

// File: rtl/imm_encode.sv
// Combinational RV32I packer: scatters the immediate into the selected format
// over the base R-type field layout and flags unrepresentable immediates.
module imm_encode
  import rv_pkg::*;
(
  input  beat_t       i_beat,
  output logic [31:0] o_word,
  output logic        o_err_range,
  output logic        o_err_align,
  output logic        o_err_format
);

  logic [31:0] w_imm;
  assign w_imm = i_beat.imm;

  always_comb begin
    o_word       = {i_beat.funct7, i_beat.rs2, i_beat.rs1, i_beat.funct3,
                    i_beat.rd, i_beat.opcode};
    o_err_range  = 1'b0;
    o_err_align  = 1'b0;
    o_err_format = 1'b0;
    case (imm_src_e'(i_beat.imm_src))
      IMM_I: begin
        o_word[31:20] = w_imm[11:0];
        o_err_range   = w_imm[31:11] != {21{w_imm[11]}};
      end
      IMM_S: begin
        o_word[31:25] = w_imm[11:5];
        o_word[11:7]  = w_imm[4:0];
        o_err_range   = w_imm[31:11] != {21{w_imm[11]}};
      end
      IMM_B: begin
        o_word[31]    = w_imm[12];
        o_word[30:25] = w_imm[10:5];
        o_word[11:8]  = w_imm[4:1];
        o_word[7]     = w_imm[11];
        o_err_range   = w_imm[31:12] != {20{w_imm[12]}};
        o_err_align   = w_imm[0];
      end
      IMM_J: begin
        o_word[31]    = w_imm[20];
        o_word[30:21] = w_imm[10:1];
        o_word[20]    = w_imm[11];
        o_word[19:12] = w_imm[19:12];
        o_err_range   = w_imm[31:20] != {12{w_imm[20]}};
        o_err_align   = w_imm[0];
      end
      // U-type can only express the upper 20 bits
      IMM_U: begin
        o_word[31:12] = w_imm[31:12];
        o_err_range   = |w_imm[11:0];
      end
      default: o_err_format = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Program loader: captures a decoded beat, packs it, and writes the word into
// imem at an auto-incrementing address, collecting sticky error status.
module imm_packer
  import rv_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_packer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_e;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;

  state_e            r_state;
  beat_t             r_beat;
  logic              r_last;
  logic              r_pend_range, r_pend_align, r_pend_format;
  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_done, r_full;
  logic              r_err_range, r_err_align, r_err_format;

  beat_t       w_beat;
  logic [31:0] w_word;
  logic        w_err_range, w_err_align, w_err_format;

  assign w_beat.imm     = bus.in_imm;
  assign w_beat.imm_src = bus.in_imm_src;
  assign w_beat.opcode  = bus.in_opcode;
  assign w_beat.rd      = bus.in_rd;
  assign w_beat.rs1     = bus.in_rs1;
  assign w_beat.rs2     = bus.in_rs2;
  assign w_beat.funct3  = bus.in_funct3;
  assign w_beat.funct7  = bus.in_funct7;

  imm_encode u_encode (
    .i_beat      (r_beat),
    .o_word      (w_word),
    .o_err_range (w_err_range),
    .o_err_align (w_err_align),
    .o_err_format(w_err_format)
  );

  // The write strobe is decided in PACK so that it is high during WRITE itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_last        <= 1'b0;
      r_pend_range  <= 1'b0;
      r_pend_align  <= 1'b0;
      r_pend_format <= 1'b0;
      r_in_ready    <= 1'b1;
      r_we          <= 1'b0;
      r_addr        <= BASE;
      r_wdata       <= '0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_full        <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_align   <= 1'b0;
      r_err_format  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (bus.start) begin
        r_state      <= IDLE;
        r_in_ready   <= 1'b1;
        r_addr       <= BASE;
        r_count      <= '0;
        r_done       <= 1'b0;
        r_full       <= 1'b0;
        r_err_range  <= 1'b0;
        r_err_align  <= 1'b0;
        r_err_format <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.in_valid && r_in_ready) begin
              r_beat     <= w_beat;
              r_last     <= bus.in_last;
              r_in_ready <= 1'b0;
              r_state    <= PACK;
            end
          end
          PACK: begin
            r_pend_range  <= w_err_range;
            r_pend_align  <= w_err_align;
            r_pend_format <= w_err_format;
            r_wdata       <= w_word;
            r_we          <= !(w_err_range || w_err_align || w_err_format);
            r_state       <= WRITE;
          end
          WRITE: begin
            if (r_we) begin
              r_addr  <= r_addr + ADDR_ONE;
              r_count <= r_count + CNT_ONE;
              if (r_addr == LAST_ADDR) r_full <= 1'b1;
            end
            r_err_range  <= r_err_range  | r_pend_range;
            r_err_align  <= r_err_align  | r_pend_align;
            r_err_format <= r_err_format | r_pend_format;
            r_done       <= r_last;
            r_in_ready   <= !r_last && !(r_full || (r_we && r_addr == LAST_ADDR));
            r_state      <= r_last ? DONE : IDLE;
          end
          DONE:    r_state <= DONE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.word_count = r_count;
  assign bus.done       = r_done;
  assign bus.full       = r_full;
  assign bus.err_range  = r_err_range;
  assign bus.err_align  = r_err_align;
  assign bus.err_format = r_err_format;

endmodule

// File: tb/tb_imm_packer.sv
// Directed self-checking bench for imm_packer, run with a 4-word imem so the
// full/wrap behaviour is reachable.
module tb_imm_packer;
  import rv_pkg::*;

  localparam int ADDR_W = 2;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  logic        obsReady;
  logic        obsWePack;
  logic        obsWe;
  logic [31:0] obsAddr;
  logic [31:0] obsWdata;
  int          weSeen;

  logic [31:0] fullWords [4];

  imm_packer_if #(.ADDR_W(ADDR_W)) bus ();

  imm_packer #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; drives one beat and records PACK/WRITE outputs
  task automatic applyStimulus(input logic [31:0] imm, input logic [2:0] src,
                               input logic [6:0] opcode, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic last);
    bus.in_imm     = imm;
    bus.in_imm_src = src;
    bus.in_opcode  = opcode;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_funct3  = f3;
    bus.in_funct7  = f7;
    bus.in_last    = last;
    bus.in_valid   = 1'b1;
    obsReady       = bus.in_ready;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    obsWePack    = bus.imem_we;
    @(negedge clk);
    obsWe    = bus.imem_we;
    obsAddr  = 32'(bus.imem_addr);
    obsWdata = bus.imem_wdata;
    @(negedge clk);
  endtask

  task automatic pulseStart(input logic withValid);
    bus.start    = 1'b1;
    bus.in_valid = withValid;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic countWrites(input int cycles);
    weSeen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.imem_we) weSeen++;
    end
  endtask

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    fullWords[0]   = 32'h00000093;
    fullWords[1]   = 32'h00100113;
    fullWords[2]   = 32'h00200193;
    fullWords[3]   = 32'h00300213;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_imm     = '0;
    bus.in_imm_src = '0;
    bus.in_opcode  = '0;
    bus.in_rd      = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_funct3  = '0;
    bus.in_funct7  = '0;
    bus.in_last    = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_addr", 32'(bus.imem_addr), 32'd0);
    checkOutput("rst_status", {26'd0, bus.imem_we, bus.done, bus.full, bus.err_range,
                               bus.err_align, bus.err_format}, 32'd0);
    checkOutput("rst_count", 32'(bus.word_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // I-type with all-ones immediate
    applyStimulus(32'hFFFFFFFF, 3'b000, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("i_accept", 32'(obsReady), 32'd1);
    checkOutput("i_we_early", 32'(obsWePack), 32'd0);
    checkOutput("i_we", 32'(obsWe), 32'd1);
    checkOutput("i_addr", obsAddr, 32'd0);
    checkOutput("i_wdata", obsWdata, 32'hFFF00093);
    checkOutput("i_count", 32'(bus.word_count), 32'd1);
    checkOutput("i_next_addr", 32'(bus.imem_addr), 32'd1);

    pulseStart(1'b0);
    applyStimulus(32'd8, 3'b001, OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 1'b0);
    checkOutput("s_addr", obsAddr, 32'd0);
    checkOutput("s_wdata", obsWdata, 32'h0020A423);
    applyStimulus(32'h12345000, 3'b100, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("u_addr", obsAddr, 32'd1);
    checkOutput("u_wdata", obsWdata, 32'h123452B7);
    checkOutput("su_count", 32'(bus.word_count), 32'd2);

    pulseStart(1'b0);
    applyStimulus(32'hFFFFFFFC, 3'b010, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("b_wdata", obsWdata, 32'hFE000EE3);
    applyStimulus(32'd8, 3'b011, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("j_wdata", obsWdata, 32'h008000EF);
    checkOutput("j_addr", obsAddr, 32'd1);

    pulseStart(1'b0);
    applyStimulus(32'd3, 3'b010, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("align_we", 32'(obsWe), 32'd0);
    checkOutput("align_errs", {29'd0, bus.err_range, bus.err_align, bus.err_format},
                32'b010);
    checkOutput("align_addr", 32'(bus.imem_addr), 32'd0);
    applyStimulus(32'h00000800, 3'b000, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("range_we", 32'(obsWe), 32'd0);
    checkOutput("range_errs", {29'd0, bus.err_range, bus.err_align, bus.err_format},
                32'b110);
    applyStimulus(32'd0, 3'b111, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("format_we", 32'(obsWe), 32'd0);
    checkOutput("format_errs", {29'd0, bus.err_range, bus.err_align, bus.err_format},
                32'b111);
    applyStimulus(32'hFFFFFFFF, 3'b000, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("after_err_we", 32'(obsWe), 32'd1);
    checkOutput("after_err_addr", obsAddr, 32'd0);
    checkOutput("after_err_count", 32'(bus.word_count), 32'd1);

    // Fill the 4-word imem, then try one more beat
    pulseStart(1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'(i), 3'b000, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
      checkOutput($sformatf("fill%0d_addr", i), obsAddr, 32'(i));
      checkOutput($sformatf("fill%0d_wdata", i), obsWdata, fullWords[i]);
    end
    checkOutput("full_flag", 32'(bus.full), 32'd1);
    checkOutput("full_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_addr", 32'(bus.imem_addr), 32'd0);
    checkOutput("full_count", 32'(bus.word_count), 32'd4);
    applyStimulus(32'd5, 3'b000, OP_IMM, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("fifth_we", 32'({obsWePack, obsWe}), 32'd0);
    checkOutput("fifth_count", 32'(bus.word_count), 32'd4);
    pulseStart(1'b0);
    checkOutput("restart_full", 32'(bus.full), 32'd0);
    checkOutput("restart_count", 32'(bus.word_count), 32'd0);
    checkOutput("restart_ready", 32'(bus.in_ready), 32'd1);

    // Session ending on the second beat
    applyStimulus(32'd1, 3'b000, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    applyStimulus(32'd2, 3'b000, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1);
    checkOutput("last_we", 32'(obsWe), 32'd1);
    checkOutput("done_flag", 32'(bus.done), 32'd1);
    checkOutput("done_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("done_hold", 32'({bus.done, bus.in_ready}), 32'b10);
    pulseStart(1'b1);
    checkOutput("done_cleared", 32'({bus.done, bus.in_ready}), 32'b01);
    checkOutput("done_restart_count", 32'(bus.word_count), 32'd0);
    pulseStart(1'b1);
    checkOutput("start_prio_ready", 32'(bus.in_ready), 32'd1);
    countWrites(4);
    checkOutput("start_prio_no_write", 32'(weSeen), 32'd0);

    // Async reset while a beat sits in PACK
    applyStimulus(32'd4, 3'b000, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0);
    checkOutput("pre_rst_count", 32'(bus.word_count), 32'd1);
    bus.in_imm   = 32'd7;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_we", 32'(bus.imem_we), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mid_rst_addr_count", 32'({bus.imem_addr, bus.word_count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    countWrites(3);
    checkOutput("post_rst_no_write", 32'(weSeen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/imm_packer.md
Name: imm_packer

Overview:
- Inverse of the core's immediate extender: takes decoded RV32I fields plus a full 32-bit immediate and an imm_src format code, and packs them into a 32-bit instruction word.
- Checks that the immediate is representable in the selected format, then writes the packed word into instruction memory at an auto-incrementing address.
- Used as the program loader / self-test instruction generator in front of imem.

Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2**ADDR_W words.
- BASE_ADDR, 0, first imem word address after reset or start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; restarts the load session.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_imm  in  32  immediate value, byte offset for B/J.
- in_imm_src  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U.
- in_opcode  in  7  opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7.
- in_last  in  1  beat is the final instruction of the session.
- imem_we  out  1  write strobe, one cycle.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  packed instruction.
- word_count  out  ADDR_W+1  words written this session.
- done, full, err_range, err_align, err_format  out  1 each  sticky status.

Behaviour:
- Reset: state IDLE; imem_addr=BASE_ADDR; all other outputs 0; in_ready=1.
- FSM states IDLE, PACK, WRITE, DONE.
- IDLE: in_ready=1 unless full. An accepted beat (in_valid && in_ready) is captured into an input register; next state is PACK.
- PACK, 1 cycle: encode the word and evaluate checks into registers; next state is WRITE.
- WRITE, 1 cycle:
  - If no error: imem_we=1 with the registered addr/wdata, then imem_addr++ and word_count++.
  - If any check failed: no write, addr unchanged, and the matching sticky error bit is set.
  - Next state is DONE if the beat's in_last was set, otherwise IDLE.
- Latency: accept at cycle N gives imem_we at N+2. Throughput is one beat per 3 cycles. in_ready is 0 in PACK, WRITE and DONE.
- Packing (fields common to all formats: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25]; the immediate overwrites the bits it occupies):
  - I: [31:20]=imm[11:0]; rs2 and funct7 are ignored.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]; rd is ignored.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- Checks:
  - err_range for I/S: imm[31:11] must all equal imm[11].
  - err_range for B: imm[31:12] must all equal imm[12].
  - err_range for J: imm[31:20] must all equal imm[20].
  - err_range for U: imm[11:0] must be 0.
  - err_align for B/J: imm[0] must be 0.
  - err_format: in_imm_src values 101–111.
  - Multiple errors on one beat set every applicable bit.
- full: set when a write occurs at address 2**ADDR_W-1. imem_addr wraps to 0 but no further beat is accepted.
- DONE: done=1, in_ready=0; the state is held until start.
- start, in any state:
  - Next cycle: IDLE; imem_addr=BASE_ADDR; word_count, done, full and all err_* cleared.
  - An in-flight beat is discarded with no write.
  - start has priority over a simultaneous in_valid; that beat is not accepted.
- rst_n low mid-operation clears everything immediately; imem_we drops asynchronously.

Decomposition:
- Shared package rv_pkg: imm_src_e enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U), opcode localparams (OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC), and a packed field struct for the input beat.
- Sub-module imm_encode: purely combinational packing plus range/align/format checks. imm_packer holds the FSM, registers, address and count.

Test Plan:
- I: imm=FFFFFFFF, src=000, opcode=0010011, rd=1, rs1=0, funct3=0 -> imem_we at N+2, addr 0, wdata FFF00093.
- S then U back-to-back:
  - S: imm=8, opcode=0100011, funct3=010, rs1=1, rs2=2 -> wdata 0020A423 at addr 0.
  - U: imm=12345000, opcode=0110111, rd=5 -> wdata 123452B7 at addr 1; word_count=2.
- B/J:
  - B: imm=FFFFFFFC, opcode=1100011, rd/rs1/rs2/funct3=0 -> FE000EE3.
  - J: imm=8, opcode=1101111, rd=1 -> 008000EF.
- Errors:
  - B with imm=3 -> err_align=1, no imem_we, addr unchanged.
  - I with imm=00000800 -> err_range=1.
  - src=111 -> err_format=1.
  - A following valid beat still writes.
- ADDR_W=2: four good beats -> full=1, in_ready=0, imem_addr=0; fifth beat is not accepted. start -> full=0, word_count=0, in_ready=1.
- in_last on beat 2 -> done=1 after its WRITE and in_ready stays 0. start asserted together with in_valid -> beat ignored.
- rst_n pulsed during PACK -> no imem_we; all outputs at reset values.
